pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the system PLL (100.663296 MHz / 50.331648 MHz outputs) and consumes its asynchronous `locked` flag.
- Pulses the PLL reset, qualifies lock over a hold window, then releases staged resets: system first, core after a gap.
- On lock loss it re-asserts all downstream resets and counts the event.
- Runs on the free-running 50.0 MHz reference clock, never on a PLL output, so it keeps operating while the PLL is held in reset.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the locked-input synchroniser (minimum 2)
- PLL_RST_CYC, 8, cycles `pll_rst_o` is held high per reset attempt
- LOCK_HOLD, 1024, consecutive synchronised-locked cycles needed before lock is declared stable
- STAGE_GAP, 16, cycles between `sys_reset_o` release and `core_reset_o` release; also the software-reset pulse length
- LOCK_TIMEOUT, 65536, cycles spent waiting for lock before the PLL reset is retried

Ports:
- clk, in, 1, free-running 50 MHz reference clock
- rst_n, in, 1, asynchronous active-low reset
- pll_locked_i, in, 1, PLL locked flag, asynchronous to `clk`
- sw_reset_i, in, 1, synchronous core-reset request, level-sensitive
- pll_rst_o, out, 1, active-high reset to the PLL
- sys_reset_o, out, 1, active-high system reset
- core_reset_o, out, 1, active-high core reset
- ready_o, out, 1, high only in RUN
- lock_loss_cnt_o, out, 8, lock losses seen after first stable lock, saturating
- retry_cnt_o, out, 8, lock-timeout retries, saturating

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (`rst_n`). All flops clear asynchronously on `rst_n` low; release is synchronous to `clk`.
- Reset values: state=PLL_RST, pll_rst_o=1, sys_reset_o=1, core_reset_o=1, ready_o=0, both counters=0, all synchroniser flops=0, timer=0.
- Lock input: `pll_locked_i` passes through SYNC_STAGES flops before use; `lock_s` is the synchronised value. No other use of the raw input.
- Timer: one shared down/up counter, width clog2(max(LOCK_TIMEOUT, LOCK_HOLD)) + 1, cleared on every state entry.
- Outputs are registered and decoded from the state: all three resets high in PLL_RST, WAIT_LOCK and STABLE; sys_reset_o low in REL_SYS, RUN and SW_RST; core_reset_o low only in RUN; ready_o = (state == RUN).
- FSM:
  - PLL_RST: pll_rst_o=1. After PLL_RST_CYC cycles → WAIT_LOCK.
  - WAIT_LOCK: pll_rst_o=0. If lock_s=1 → STABLE. Else, when the timer reaches LOCK_TIMEOUT-1 → PLL_RST and retry_cnt increments.
  - STABLE: if lock_s=0 → WAIT_LOCK (timer restarts, no loss counted). When LOCK_HOLD consecutive lock_s=1 cycles are complete → REL_SYS.
  - REL_SYS: after STAGE_GAP cycles → RUN.
  - RUN: idle here while lock is held and no software reset is requested.
  - SW_RST: core_reset_o=1 for STAGE_GAP cycles, then → RUN. If sw_reset_i is still high on exit, re-enter SW_RST on the next cycle.
- Lock loss: lock_s=0 in REL_SYS, RUN or SW_RST → WAIT_LOCK on the next edge. All resets reassert in that same cycle, and lock_loss_cnt increments.
- Simultaneous events:
  - sw_reset_i=1 and lock_s=0 in RUN: lock loss wins.
  - sw_reset_i in any state other than RUN: ignored.
- Counters saturate at 255. They never wrap, and are cleared only by rst_n.
- Latency:
  - rst_n deassert to pll_rst_o fall: PLL_RST_CYC cycles.
  - pll_locked_i rise to sys_reset_o fall: SYNC_STAGES + LOCK_HOLD + 1 cycles (±1 for synchroniser sampling).
  - sys_reset_o fall to core_reset_o fall: STAGE_GAP cycles.

Optional Feature:
- Macro: PLL_RESET_SEQ_STATUS_EN.
- Defined: lock_loss_cnt_o and retry_cnt_o behave as specified above.
- Undefined: both counters are not built and both outputs are tied to 0. FSM behaviour and timing are identical in both builds.

Decomposition:
- Package `pll_reset_seq_pkg` holds:
  - the state enum (PLL_RST, WAIT_LOCK, STABLE, REL_SYS, RUN, SW_RST);
  - localparam CNT_W = 8;
  - a saturating-increment function.
- One sub-module, `sync_bit`: a parameterised SYNC_STAGES-deep single-bit synchroniser with asynchronous active-low clear. It is reusable for the downstream-domain reset synchronisers.
- The top level holds the FSM, the timer and the counters.

Test Plan (sim parameters: LOCK_HOLD=16, STAGE_GAP=4, LOCK_TIMEOUT=64, PLL_RST_CYC=8, SYNC_STAGES=2):
- Power-up: release rst_n, raise pll_locked_i at cycle 20 → pll_rst_o high for cycles 0–7, sys_reset_o falls at about cycle 39, core_reset_o falls 4 cycles later, ready_o=1, both counters 0.
- Lock glitch during qualification: locked high for 10 cycles, low for 1, then high → timer restarts, lock_loss_cnt stays 0, sys_reset_o releases 16+ cycles after the re-rise.
- Timeout: hold pll_locked_i low → pll_rst_o re-pulses for 8 cycles every 72 cycles; retry_cnt increments each time and saturates at 255 after 255 retries.
- Lock loss in RUN: drop pll_locked_i → within 3 cycles all resets are high, ready_o=0, lock_loss_cnt=1; restoring lock repeats the staged release.
- Software reset: 1-cycle sw_reset_i pulse in RUN → core_reset_o high for exactly 4 cycles, sys_reset_o stays low. Holding sw_reset_i high keeps core_reset_o high continuously.
- Mid-operation reset: assert rst_n in RUN → all outputs return to reset values asynchronously, before the next edge. Build without PLL_RESET_SEQ_STATUS_EN → both counter outputs read 0 throughout.

Source files
------------

// File: rtl/pll_reset_seq_pkg.sv
// ============================================================================
// Module      : pll_reset_seq_pkg
// Description : Shared state encoding, counter width and saturating increment
//               for the PLL reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_reset_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        REL_SYS   = 3'd3,
        RUN       = 3'd4,
        SW_RST    = 3'd5
    } state_e;

    localparam int CNT_W = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage : pll_reset_seq_pkg

`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_bit.sv
// ============================================================================
// Module      : sync_bit
// Description : Single-bit multi-flop synchroniser with asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    // Fewer than two flops gives no metastability protection, so clamp.
    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule : sync_bit

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Pulses the PLL reset, qualifies lock, then releases system and
//               core resets in stages; re-asserts them on lock loss.
//               Status counters built only with PLL_RESET_SEQ_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int PLL_RST_CYC  = 8,
    parameter int LOCK_HOLD    = 1024,
    parameter int STAGE_GAP    = 16,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked_i,
    input  logic             sw_reset_i,
    output logic             pll_rst_o,
    output logic             sys_reset_o,
    output logic             core_reset_o,
    output logic             ready_o,
    output logic [CNT_W-1:0] lock_loss_cnt_o,
    output logic [CNT_W-1:0] retry_cnt_o
);

    localparam int TIMER_MAX = (LOCK_TIMEOUT > LOCK_HOLD) ? LOCK_TIMEOUT : LOCK_HOLD;
    localparam int TIMER_W   = $clog2(TIMER_MAX) + 1;

    localparam logic [TIMER_W-1:0] PLL_RST_LAST = TIMER_W'(PLL_RST_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(LOCK_HOLD - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(STAGE_GAP - 1);

    logic               lock_s;
    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               restart_d;
    logic               pll_rst_q, sys_reset_q, core_reset_q, ready_q;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked_i),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        restart_d = 1'b0;
        timer_d   = timer_q + 1'b1;
        case (state_q)
            PLL_RST: begin
                if (timer_q == PLL_RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                       state_d = STABLE;
                else if (timer_q == TIMEOUT_LAST) state_d = PLL_RST;
            end
            STABLE: begin
                if (!lock_s)                   state_d = WAIT_LOCK;
                else if (timer_q == HOLD_LAST) state_d = REL_SYS;
            end
            REL_SYS: begin
                if (!lock_s)                  state_d = WAIT_LOCK;
                else if (timer_q == GAP_LAST) state_d = RUN;
            end
            RUN: begin
                timer_d = timer_q;
                if (!lock_s)         state_d = WAIT_LOCK;
                else if (sw_reset_i) state_d = SW_RST;
            end
            SW_RST: begin
                // A still-held request restarts the pulse so core reset never drops.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == GAP_LAST) begin
                    if (sw_reset_i) restart_d = 1'b1;
                    else            state_d   = RUN;
                end
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase
        if ((state_d != state_q) || restart_d) timer_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PLL_RST;
            timer_q      <= '0;
            pll_rst_q    <= 1'b1;
            sys_reset_q  <= 1'b1;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pll_rst_q    <= (state_d == PLL_RST);
            sys_reset_q  <= (state_d == PLL_RST) || (state_d == WAIT_LOCK) || (state_d == STABLE);
            core_reset_q <= (state_d != RUN);
            ready_q      <= (state_d == RUN);
        end
    end

    assign pll_rst_o    = pll_rst_q;
    assign sys_reset_o  = sys_reset_q;
    assign core_reset_o = core_reset_q;
    assign ready_o      = ready_q;

`ifdef PLL_RESET_SEQ_STATUS_EN
    logic             retry_evt, loss_evt;
    logic [CNT_W-1:0] retry_cnt_q, loss_cnt_q;

    assign retry_evt = (state_q == WAIT_LOCK) && (state_d == PLL_RST);
    assign loss_evt  = ((state_q == REL_SYS) || (state_q == RUN) || (state_q == SW_RST))
                       && (state_d == WAIT_LOCK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt_q <= '0;
            loss_cnt_q  <= '0;
        end else begin
            if (retry_evt) retry_cnt_q <= sat_inc(retry_cnt_q);
            if (loss_evt)  loss_cnt_q  <= sat_inc(loss_cnt_q);
        end
    end

    assign lock_loss_cnt_o = loss_cnt_q;
    assign retry_cnt_o     = retry_cnt_q;
`else
    assign lock_loss_cnt_o = '0;
    assign retry_cnt_o     = '0;
`endif

endmodule : pll_reset_sequencer

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Self-checking bench for pll_reset_sequencer with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int PRC  = 8;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int TMO  = 64;

`ifdef PLL_RESET_SEQ_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       locked = 1'b0;
    logic       sw     = 1'b0;
    logic       pll_rst, sys_rst, core_rst, ready;
    logic [7:0] loss_cnt, retry_cnt;

    int checks   = 0;
    int failures = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES  (SYNC),
        .PLL_RST_CYC  (PRC),
        .LOCK_HOLD    (HOLD),
        .STAGE_GAP    (GAP),
        .LOCK_TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked_i    (locked),
        .sw_reset_i      (sw),
        .pll_rst_o       (pll_rst),
        .sys_reset_o     (sys_rst),
        .core_reset_o    (core_rst),
        .ready_o         (ready),
        .lock_loss_cnt_o (loss_cnt),
        .retry_cnt_o     (retry_cnt)
    );

    always #5 clk = ~clk;

    // Model: phase plus the cycle number at which that phase was entered.
    localparam int P_PLLRST = 0, P_WAIT = 1, P_STABLE = 2, P_RELSYS = 3, P_RUN = 4, P_SWRST = 5;
    int m_ph, m_cyc, m_entry, m_loss, m_retry;
    bit m_q[$];

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic model_reset();
        m_ph = P_PLLRST; m_cyc = 0; m_entry = 0; m_loss = 0; m_retry = 0;
        m_q.delete();
        for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit s, again;
        int age, nxt;
        m_q.push_back(locked);
        s     = m_q.pop_front();
        age   = m_cyc - m_entry;
        nxt   = m_ph;
        again = 1'b0;
        if (m_ph == P_PLLRST) begin
            if (age == PRC - 1) nxt = P_WAIT;
        end else if (m_ph == P_WAIT) begin
            if (s) nxt = P_STABLE;
            else if (age == TMO - 1) begin nxt = P_PLLRST; m_retry = sat(m_retry); end
        end else if (m_ph == P_STABLE) begin
            if (!s) nxt = P_WAIT;
            else if (age == HOLD - 1) nxt = P_RELSYS;
        end else if (!s) begin
            nxt = P_WAIT; m_loss = sat(m_loss);
        end else if (m_ph == P_RELSYS) begin
            if (age == GAP - 1) nxt = P_RUN;
        end else if (m_ph == P_RUN) begin
            if (sw) nxt = P_SWRST;
        end else begin
            if (age == GAP - 1) begin
                if (sw) again = 1'b1; else nxt = P_RUN;
            end
        end
        if (nxt != m_ph || again) m_entry = m_cyc + 1;
        m_ph  = nxt;
        m_cyc = m_cyc + 1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("pll_rst_o",    pll_rst,   int'(m_ph == P_PLLRST));
        check("sys_reset_o",  sys_rst,   int'(m_ph == P_PLLRST || m_ph == P_WAIT || m_ph == P_STABLE));
        check("core_reset_o", core_rst,  int'(m_ph != P_RUN));
        check("ready_o",      ready,     int'(m_ph == P_RUN));
        check("lock_loss",    loss_cnt,  STATUS ? m_loss : 0);
        check("retry_cnt",    retry_cnt, STATUS ? m_retry : 0);
    end

    task automatic tick(input bit lk, input bit s);
        locked = lk;
        sw     = s;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic restart();
        locked = 1'b0; sw = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int pll_fall, sys_fall, core_fall, pll_rise, cnt_a, cnt_b;
        bit lk;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pll",   pll_rst,   1);
        check("rst_sys",   sys_rst,   1);
        check("rst_core",  core_rst,  1);
        check("rst_ready", ready,     0);
        check("rst_loss",  loss_cnt,  0);
        check("rst_retry", retry_cnt, 0);

        // Power-up with lock arriving at cycle 20
        restart();
        pll_fall = -1; sys_fall = -1; core_fall = -1;
        for (int k = 0; k < 50; k++) begin
            tick(k >= 20, 1'b0);
            if (pll_fall < 0 && !pll_rst)  pll_fall  = k;
            if (sys_fall < 0 && !sys_rst)  sys_fall  = k;
            if (core_fall < 0 && !core_rst) core_fall = k;
        end
        check("pwr_pll_fall",  pll_fall,  7);
        check("pwr_sys_fall",  sys_fall,  38);
        check("pwr_core_fall", core_fall, 42);
        check("pwr_ready",     ready,     1);

        // One-cycle lock glitch during qualification
        restart();
        sys_fall = -1;
        for (int k = 0; k < 70; k++) begin
            tick(k >= 20 && k != 30, 1'b0);
            if (sys_fall < 0 && !sys_rst) sys_fall = k;
        end
        check("glitch_sys_fall", sys_fall, 49);
        check("glitch_loss",     loss_cnt, 0);

        // Lock loss in RUN
        repeat (3) tick(1'b0, 1'b0);
        check("loss_sys",   sys_rst,  1);
        check("loss_core",  core_rst, 1);
        check("loss_ready", ready,    0);
        check("loss_cnt",   loss_cnt, STATUS ? 1 : 0);
        repeat (30) tick(1'b1, 1'b0);
        check("relock_ready", ready, 1);

        // Software reset: single pulse, then held
        tick(1'b1, 1'b1);
        cnt_a = int'(core_rst); cnt_b = int'(sys_rst);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0);
            cnt_a += int'(core_rst); cnt_b += int'(sys_rst);
        end
        check("sw_pulse_core_cycles", cnt_a, 4);
        check("sw_pulse_sys_high",    cnt_b, 0);
        cnt_a = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1'b1, 1'b1);
            cnt_a += int'(!core_rst);
        end
        check("sw_hold_core_low", cnt_a, 0);
        repeat (10) tick(1'b1, 1'b0);
        check("sw_back_ready", ready, 1);

        // Asynchronous reset in RUN, sampled before the next edge
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_pll",   pll_rst,   1);
        check("async_sys",   sys_rst,   1);
        check("async_core",  core_rst,  1);
        check("async_ready", ready,     0);
        check("async_loss",  loss_cnt,  0);
        check("async_retry", retry_cnt, 0);

        // Lock timeout retries and counter saturation
        restart();
        pll_rise = -1;
        for (int k = 0; k < 150; k++) begin
            tick(1'b0, 1'b0);
            if (pll_rise < 0 && k > 7 && pll_rst) pll_rise = k;
        end
        check("tmo_pll_rise", pll_rise,  71);
        check("tmo_retry2",   retry_cnt, STATUS ? 2 : 0);
        for (int k = 0; k < 255 * 72; k++) tick(1'b0, 1'b0);
        check("tmo_retry_sat", retry_cnt, STATUS ? 255 : 0);

        // Randomised lock and software-reset activity
        restart();
        lk = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (lk) begin if ($urandom_range(0, 99) < 2) lk = 1'b0; end
            else    begin if ($urandom_range(0, 99) < 8) lk = 1'b1; end
            tick(lk, $urandom_range(0, 99) < 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pll_reset_sequencer

`default_nettype wire
